// File: rtl/res_st_pkg.sv
// Shared types for the reservation station: slot addressing, the renamed
// micro-op cell format and the CDB operand-capture helper.
package qu_common;

    localparam int RES_ST_ADDR_WIDTH = 3;
    localparam int RES_ST_SIZE       = 1 << RES_ST_ADDR_WIDTH;
    localparam int PHY_RF_ADDR_WIDTH = 6;

    typedef logic [RES_ST_ADDR_WIDTH-1:0] res_st_addr_t;
    typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_addr_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SLT = 4'd7
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [11:0] imm;
    } uop_t;

    typedef struct packed {
        logic        valid;
        uop_t        uop;
        phy_addr_t   rd_phy;
        phy_addr_t   rs1_phy;
        logic        rs1_ready;
        logic [31:0] rs1_data;
        phy_addr_t   rs2_phy;
        logic        rs2_ready;
        logic [31:0] rs2_data;
    } res_st_cell_t;

    // Capture a CDB broadcast into any still-waiting operand whose tag matches.
    // Both operands may match the same broadcast.
    function automatic res_st_cell_t cdb_capture(
        input res_st_cell_t c,
        input logic         cdb_valid,
        input phy_addr_t    cdb_tag,
        input logic [31:0]  cdb_data
    );
        res_st_cell_t r;
        r = c;
        if (cdb_valid && !c.rs1_ready && (c.rs1_phy == cdb_tag)) begin
            r.rs1_ready = 1'b1;
            r.rs1_data  = cdb_data;
        end
        if (cdb_valid && !c.rs2_ready && (c.rs2_phy == cdb_tag)) begin
            r.rs2_ready = 1'b1;
            r.rs2_data  = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/res_st_age_select.sv
// Age matrix and oldest-eligible selection. age[i][j] = 1 means slot i was
// written before slot j; rows of invalid slots may hold stale bits, which is
// harmless because only eligible (hence valid) slots take part in selection
// and a slot's row is cleared when it is written.
module res_st_age_select
    import qu_common::*;
#(
    parameter int N = RES_ST_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] valid,
    input  logic [N-1:0] eligible,
    input  logic [N-1:0] wr_vec,
    output logic [N-1:0] grant,
    output res_st_addr_t grant_idx,
    output logic         grant_any
);

    logic [N-1:0] age [N];

    // Record the new slot as younger than every currently valid slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (wr_vec[k]) begin
                    for (int j = 0; j < N; j++) begin
                        if (valid[j]) begin
                            age[j][k] <= 1'b1;
                        end
                    end
                    age[k] <= '0;
                end
            end
        end
    end

    // Grant the eligible slot that no other eligible slot is older than.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        grant_any = |eligible;
        for (int i = 0; i < N; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < N; j++) begin
                if (eligible[j] && age[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = res_st_addr_t'(i);
            end
        end
    end

endmodule

// File: rtl/res_st.sv
// Reservation station: accepts renamed uops into advertised free slots,
// captures operands from the CDB, and issues the oldest ready entry through
// a one-deep issue register with a valid/ready handshake.
module res_st
    import qu_common::*;
#(
    parameter int RES_ST_SIZE       = qu_common::RES_ST_SIZE,
    parameter int PHY_RF_ADDR_WIDTH = qu_common::PHY_RF_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush_in,
    input  logic                         res_st_wr_en_in,
    input  res_st_addr_t                 res_st_wr_addr_in,
    input  res_st_cell_t                 res_st_data_in,
    output res_st_addr_t                 free_addr_out,
    output logic                         full_out,
    input  logic                         cdb_valid_in,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] cdb_tag_in,
    input  logic [31:0]                  cdb_data_in,
    output logic                         issue_valid_out,
    output res_st_cell_t                 issue_data_out,
    input  logic                         issue_ready_in
);

    logic [RES_ST_SIZE-1:0] valid;
    res_st_cell_t           cells [RES_ST_SIZE];

    logic [RES_ST_SIZE-1:0] eligible;
    logic [RES_ST_SIZE-1:0] wr_vec;
    logic [RES_ST_SIZE-1:0] grant;
    res_st_addr_t           sel_idx;
    logic                   sel_any;
    logic                   wr_accept;
    logic                   issue_load;
    res_st_cell_t           incoming;
    res_st_cell_t           sel_cell;

    assign wr_accept  = en && res_st_wr_en_in && !flush_in && !valid[res_st_wr_addr_in];
    assign issue_load = en && !flush_in && (!issue_valid_out || issue_ready_in);
    assign wr_vec     = wr_accept ? (RES_ST_SIZE'(1) << res_st_wr_addr_in) : '0;
    assign incoming   = cdb_capture(res_st_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in);

    // Advertise the lowest free slot and the full condition from registered valid bits.
    always_comb begin
        free_addr_out = '0;
        full_out      = &valid;
        for (int i = RES_ST_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_addr_out = res_st_addr_t'(i);
            end
        end
    end

    // An entry may issue once both operands are held in registered state.
    always_comb begin
        for (int i = 0; i < RES_ST_SIZE; i++) begin
            eligible[i] = valid[i] && cells[i].rs1_ready && cells[i].rs2_ready;
        end
        // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<='.
        sel_cell       = cells[sel_idx];
        sel_cell.valid = 1'b1;
    end

    res_st_age_select #(
        .N(RES_ST_SIZE)
    ) u_age_select (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .eligible  (eligible),
        .wr_vec    (wr_vec),
        .grant     (grant),
        .grant_idx (sel_idx),
        .grant_any (sel_any)
    );

    // Slot occupancy: set by an accepted write, cleared by issue, flush or reset.
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            valid <= '0;
        end else begin
            valid <= (valid & ~(issue_load ? grant : '0)) | wr_vec;
        end
    end

    // Slot payload: written on accept, otherwise snoops the CDB every edge.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; the valid bits alone decide whether contents matter.
        for (int i = 0; i < RES_ST_SIZE; i++) begin
            if (wr_accept && (res_st_wr_addr_in == res_st_addr_t'(i))) begin
                cells[i] <= incoming;
            end else begin
                cells[i] <= cdb_capture(cells[i], cdb_valid_in, cdb_tag_in, cdb_data_in);
            end
        end
    end

    // Issue register: reload when empty or being consumed, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_out <= 1'b0;
            issue_data_out  <= '0;
        end else if (flush_in) begin
            issue_valid_out <= 1'b0;
        end else if (issue_load) begin
            issue_valid_out <= sel_any;
            if (sel_any) begin
                issue_data_out <= sel_cell;
            end
        end
    end

endmodule

// File: tb/tb_res_st.sv
// Bench for res_st: directed scenarios plus random traffic, checked against a
// queue-ordered behavioural model through an issue scoreboard.
module tb_res_st;
    import qu_common::*;

    logic         clk;
    logic         rst;
    logic         en;
    logic         flush_in;
    logic         res_st_wr_en_in;
    res_st_addr_t res_st_wr_addr_in;
    res_st_cell_t res_st_data_in;
    res_st_addr_t free_addr_out;
    logic         full_out;
    logic         cdb_valid_in;
    logic [5:0]   cdb_tag_in;
    logic [31:0]  cdb_data_in;
    logic         issue_valid_out;
    res_st_cell_t issue_data_out;
    logic         issue_ready_in;

    res_st dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .flush_in          (flush_in),
        .res_st_wr_en_in   (res_st_wr_en_in),
        .res_st_wr_addr_in (res_st_wr_addr_in),
        .res_st_data_in    (res_st_data_in),
        .free_addr_out     (free_addr_out),
        .full_out          (full_out),
        .cdb_valid_in      (cdb_valid_in),
        .cdb_tag_in        (cdb_tag_in),
        .cdb_data_in       (cdb_data_in),
        .issue_valid_out   (issue_valid_out),
        .issue_data_out    (issue_data_out),
        .issue_ready_in    (issue_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: slots plus an arrival-order list of occupied slots.
    logic [7:0]   m_valid = '0;
    res_st_cell_t m_cell [8];
    int           m_order [$];
    logic         m_iv = 1'b0;
    res_st_cell_t m_idata = '0;
    res_st_cell_t exp_q [$];

    function automatic res_st_cell_t m_snoop(input res_st_cell_t c);
        res_st_cell_t r;
        r = c;
        if (cdb_valid_in) begin
            if (!r.rs1_ready && r.rs1_phy == cdb_tag_in) begin
                r.rs1_ready = 1'b1;
                r.rs1_data  = cdb_data_in;
            end
            if (!r.rs2_ready && r.rs2_phy == cdb_tag_in) begin
                r.rs2_ready = 1'b1;
                r.rs2_data  = cdb_data_in;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] m_free();
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!m_valid[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic model_step();
        logic wr_ok;
        int   pos;
        int   s;
        if (rst) begin
            m_valid = '0;
            m_order.delete();
            m_iv    = 1'b0;
            m_idata = '0;
            return;
        end
        if (flush_in) begin
            m_valid = '0;
            m_order.delete();
            m_iv = 1'b0;
            return;
        end
        wr_ok = en && res_st_wr_en_in && !m_valid[res_st_wr_addr_in];
        if (en && m_iv && issue_ready_in) exp_q.push_back(m_idata);
        if (en && (!m_iv || issue_ready_in)) begin
            pos = -1;
            foreach (m_order[k]) begin
                if (pos < 0 && m_cell[m_order[k]].rs1_ready && m_cell[m_order[k]].rs2_ready) pos = k;
            end
            if (pos >= 0) begin
                s             = m_order[pos];
                m_idata       = m_cell[s];
                m_idata.valid = 1'b1;
                m_iv          = 1'b1;
                m_valid[s]    = 1'b0;
                m_order.delete(pos);
            end else begin
                m_iv = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i]) m_cell[i] = m_snoop(m_cell[i]);
        end
        if (wr_ok) begin
            m_cell[res_st_wr_addr_in]  = m_snoop(res_st_data_in);
            m_valid[res_st_wr_addr_in] = 1'b1;
            m_order.push_back(int'(res_st_wr_addr_in));
        end
    endtask

    // Model process: compare advertised state, then advance the model over the coming edge.
    initial begin
        @(posedge clk);
        forever begin
            #6;
            check("full_out", 128'(full_out), 128'(&m_valid));
            check("free_addr_out", 128'(free_addr_out), 128'(m_free()));
            check("issue_valid_out", 128'(issue_valid_out), 128'(m_iv));
            model_step();
            @(posedge clk);
        end
    end

    // Monitor: every handshake the DUT completes must match the next expected issue.
    initial begin
        @(posedge clk);
        forever begin
            #7;
            if (!rst && !flush_in && en && issue_valid_out && issue_ready_in) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL issue_unexpected: got rd_phy %0d expected no issue", issue_data_out.rd_phy);
                end else begin
                    check("issue_data", 128'(issue_data_out), 128'(exp_q.pop_front()));
                end
            end
            @(posedge clk);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        res_st_wr_en_in = 1'b0;
        cdb_valid_in    = 1'b0;
        flush_in        = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic res_st_cell_t mk(input logic [5:0] rd, input logic [5:0] t1, input logic r1,
                                        input logic [31:0] d1, input logic [5:0] t2, input logic r2,
                                        input logic [31:0] d2);
        res_st_cell_t c;
        c.valid     = 1'b0;
        c.uop.op    = op_t'(4'($urandom_range(0, 7)));
        c.uop.imm   = 12'($urandom);
        c.rd_phy    = rd;
        c.rs1_phy   = t1;
        c.rs1_ready = r1;
        c.rs1_data  = d1;
        c.rs2_phy   = t2;
        c.rs2_ready = r2;
        c.rs2_data  = d2;
        return c;
    endfunction

    task automatic wr(input logic [2:0] a, input res_st_cell_t c);
        res_st_wr_en_in   = 1'b1;
        res_st_wr_addr_in = a;
        res_st_data_in    = c;
    endtask

    initial begin
        logic [5:0] t1;
        logic [5:0] t2;
        rst = 1'b1; en = 1'b1; flush_in = 1'b0; res_st_wr_en_in = 1'b0; res_st_wr_addr_in = '0;
        res_st_data_in = '0; cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0; issue_ready_in = 1'b1;
        tick(); tick();
        check("reset_issue_data", 128'(issue_data_out), 128'(0));
        rst = 1'b0;

        // Minimum latency with operands ready.
        wr(3'd0, mk(6'd9, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd4));
        tick();
        res_st_wr_en_in = 1'b0;
        check("t1_free_after_write", 128'(free_addr_out), 128'(1));
        tick();
        check("t1_issue_valid", 128'(issue_valid_out), 128'(1));
        check("t1_rs1_data", 128'(issue_data_out.rs1_data), 128'(2));
        check("t1_rs2_data", 128'(issue_data_out.rs2_data), 128'(4));
        check("t1_free_back", 128'(free_addr_out), 128'(0));
        idle(2);

        // Wakeup from the CDB; a non-matching tag does nothing.
        wr(3'd0, mk(6'd10, 6'd16, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3));
        tick();
        res_st_wr_en_in = 1'b0;
        cdb_valid_in = 1'b1; cdb_tag_in = 6'd17; cdb_data_in = 32'd99;
        tick();
        cdb_tag_in = 6'd16; cdb_data_in = 32'd5;
        tick();
        cdb_valid_in = 1'b0;
        check("t2_not_yet", 128'(issue_valid_out), 128'(0));
        tick();
        check("t2_issue_valid", 128'(issue_valid_out), 128'(1));
        check("t2_rs1_data", 128'(issue_data_out.rs1_data), 128'(5));
        idle(2);

        // Same-edge bypass into the incoming write.
        wr(3'd0, mk(6'd11, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1));
        cdb_valid_in = 1'b1; cdb_tag_in = 6'd20; cdb_data_in = 32'd7;
        tick();
        res_st_wr_en_in = 1'b0; cdb_valid_in = 1'b0;
        tick();
        check("t3_issue_valid", 128'(issue_valid_out), 128'(1));
        check("t3_rs1_data", 128'(issue_data_out.rs1_data), 128'(7));
        idle(2);

        // Fill, reject an extra write, wake all, issue oldest first.
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), mk(6'(i + 1), 6'd30, 1'b0, 32'd0, 6'd0, 1'b1, 32'(i)));
            tick();
        end
        res_st_wr_en_in = 1'b0;
        check("t4_full", 128'(full_out), 128'(1));
        check("t4_free_when_full", 128'(free_addr_out), 128'(0));
        wr(3'd3, mk(6'd60, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1));
        tick();
        res_st_wr_en_in = 1'b0;
        cdb_valid_in = 1'b1; cdb_tag_in = 6'd30; cdb_data_in = 32'd42;
        tick();
        cdb_valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_issue_order", 128'(issue_data_out.rd_phy), 128'(i + 1));
            if (i == 0) check("t4_slot0_freed", 128'(free_addr_out), 128'(0));
        end
        idle(2);

        // Stall holds the issue register; release shows the second entry.
        issue_ready_in = 1'b0;
        wr(3'd0, mk(6'd40, 6'd0, 1'b1, 32'd8, 6'd0, 1'b1, 32'd9));
        tick();
        wr(3'd1, mk(6'd41, 6'd0, 1'b1, 32'd10, 6'd0, 1'b1, 32'd11));
        tick();
        res_st_wr_en_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_stall_hold", 128'(issue_data_out.rd_phy), 128'(40));
            tick();
        end
        issue_ready_in = 1'b1;
        tick();
        check("t5_second", 128'(issue_data_out.rd_phy), 128'(41));
        idle(2);

        // Flush with three waiting entries, a pending issue and a same-cycle write.
        issue_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(3'(i), mk(6'(50 + i), 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2));
            tick();
        end
        wr(3'd5, mk(6'd55, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2));
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; res_st_wr_en_in = 1'b0;
        check("t6_issue_valid", 128'(issue_valid_out), 128'(0));
        check("t6_full", 128'(full_out), 128'(0));
        check("t6_free", 128'(free_addr_out), 128'(0));
        issue_ready_in = 1'b1;
        tick();
        check("t6_nothing_left", 128'(issue_valid_out), 128'(0));
        idle(2);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 299) == 0);
            flush_in        = ($urandom_range(0, 59) == 0);
            en              = ($urandom_range(0, 7) != 0);
            res_st_wr_en_in = 1'($urandom_range(0, 1));
            res_st_wr_addr_in = ($urandom_range(0, 3) != 0) ? free_addr_out : 3'($urandom_range(0, 7));
            t1 = 6'($urandom_range(0, 7));
            t2 = 6'($urandom_range(0, 7));
            res_st_data_in = mk(6'($urandom_range(0, 63)),
                                t1, (t1 == 6'd0) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom,
                                t2, (t2 == 6'd0) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom);
            res_st_data_in.valid = 1'($urandom_range(0, 1));
            cdb_valid_in   = ($urandom_range(0, 2) == 0);
            cdb_tag_in     = 6'($urandom_range(1, 7));
            cdb_data_in    = $urandom;
            issue_ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Drain: wake every possible tag and accept everything.
        rst = 1'b0; flush_in = 1'b0; en = 1'b1; res_st_wr_en_in = 1'b0; issue_ready_in = 1'b1;
        for (int n = 0; n < 30; n++) begin
            cdb_valid_in = 1'b1;
            cdb_tag_in   = 6'((n % 7) + 1);
            cdb_data_in  = $urandom;
            tick();
        end
        cdb_valid_in = 1'b0;
        idle(4);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        check("drained_valid", 128'(issue_valid_out), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/res_st.md
Name: res_st

Overview:
Reservation station directly downstream of the rename stage. It accepts renamed micro-ops into a slot index that it advertises to rename, and captures operand values broadcast on the common data bus (CDB) while operands wait. It then issues the oldest entry with both operands ready to the execute stage over a valid/ready handshake.

Parameters:
- RES_ST_SIZE, 8, number of entries; must equal 2**RES_ST_ADDR_WIDTH from qu_common.
- PHY_RF_ADDR_WIDTH, qu_common value (6), width of physical register tags.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  stage enable; 0 blocks writes and issue-register updates, but CDB wakeup still proceeds
- flush_in  in  1  discard all entries and any pending issue
- res_st_wr_en_in  in  1  write request from rename
- res_st_wr_addr_in  in  RES_ST_ADDR_WIDTH  target slot, res_st_addr_t
- res_st_data_in  in  res_st_cell_t  renamed uop with operand tags, ready bits and data
- free_addr_out  out  RES_ST_ADDR_WIDTH  lowest-index invalid slot; 0 when full
- full_out  out  1  all slots valid
- cdb_valid_in  in  1  CDB broadcast valid
- cdb_tag_in  in  PHY_RF_ADDR_WIDTH  physical destination being broadcast
- cdb_data_in  in  32  broadcast value
- issue_valid_out  out  1  issue register holds an entry
- issue_data_out  out  res_st_cell_t  issued entry, both operands ready
- issue_ready_in  in  1  execute stage accepts issue_data_out this cycle

Behaviour:
- Reset: all entry valid bits 0, age matrix 0, issue_valid_out 0, issue_data_out 0. After reset, full_out is 0 and free_addr_out is 0.
- full_out and free_addr_out are combinational from the current valid bits only.
- Write: accepted on an edge when en && res_st_wr_en_in && !flush_in && slot invalid. The slot is valid from the next cycle.
  - Write to an already-valid slot: ignored; entry unchanged.
  - The valid field of res_st_data_in is ignored.
- Write bypass: if cdb_valid_in and cdb_tag_in matches an incoming operand tag whose ready bit is 0, that operand is stored with ready=1 and data=cdb_data_in.
- Wakeup: on every edge, and regardless of en, each valid entry's non-ready operand with a matching tag gets ready<=1 and data<=cdb_data_in.
  - Both operands may match the same broadcast.
  - Tag 0 (x0) never waits; rename delivers it ready.
- Age: age matrix age[i][j]=1 means i is older than j. On a write to slot k: age[j][k]<=1 for every valid j, and age[k][*]<=0.
- Select (combinational): entry i is eligible if valid and both ready bits are set. The oldest eligible entry is the one with no eligible j where age[j][i]=1.
- Readiness used by select is the registered state. A wakeup at edge N makes the entry eligible in cycle N+1.
- Issue register: loads when en && !flush_in && (!issue_valid_out || issue_ready_in).
  - On load, the selected entry is copied to issue_data_out, issue_valid_out<=1, and that entry's valid<=0 on the same edge.
  - If nothing is eligible on a load edge, issue_valid_out<=0.
  - If issue_valid_out && !issue_ready_in, issue_data_out holds stable.
- Minimum latency: write at edge N (operands ready) -> issue_valid_out=1 after edge N+1.
- A slot freed by issue at edge N is advertised on free_addr_out from cycle N+1. Same-edge write and issue can never hit the same slot.
- Flush: on an edge with flush_in, all valid bits and issue_valid_out go to 0, and any write is dropped. Flush has priority over write, issue and wakeup.
- Reset mid-operation behaves as flush and also clears issue_data_out.

Decomposition:
- qu_common: RES_ST_SIZE, RES_ST_ADDR_WIDTH, res_st_addr_t, and res_st_cell_t (valid, uop_t uop, rd_phy, rs1_phy, rs1_ready, rs1_data[31:0], rs2_phy, rs2_ready, rs2_data[31:0]).
- One sub-module, res_st_age_select: holds the age matrix, takes eligible/valid/write vectors, and produces a one-hot oldest-eligible grant plus its index.

Test Plan:
- Reset, then write slot 0 (rs1 ready data 2, rs2 ready data 4, rd_phy 9); hold issue_ready_in=1 -> issue_valid_out=1 one edge later with rs1_data=2 and rs2_data=4, and free_addr_out returns to 0.
- Write slot 0 with rs1_phy 16 not ready; broadcast CDB tag 16 data 5 two cycles later -> issue one edge after the broadcast edge with rs1_data=5. A broadcast with tag 17 has no effect.
- Write slot 0 (rs1 tag 20 not ready) while CDB tag 20 data 7 is valid on the same edge -> entry stored ready and issued the next edge with rs1_data=7.
- Fill all 8 slots not ready -> full_out=1 and free_addr_out=0. A further write is ignored. Wake all with one shared tag -> issue order 0..7 (oldest first); the first issue frees slot 0.
- Hold issue_ready_in=0 with two eligible entries -> issue_data_out stable, and the second entry stays valid. Raise issue_ready_in -> the second entry appears the next edge.
- With 3 valid entries and issue_valid_out=1, assert flush_in for one cycle -> all valid 0, issue_valid_out=0, full_out=0, free_addr_out=0; a same-cycle write is dropped.
